// File: rtl/shift_reg_mcu_spi_rx_if.sv
// Core-side word handshake of the MCU->FPGA SPI receiver.
// The receiver drives the word and status flags; the consumer returns data_ack.
interface shift_reg_mcu_spi_rx_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ack;
  logic             overrun;
  logic             frame_err;
  logic             busy;

  modport master (
    output data_out,
    output data_valid,
    output overrun,
    output frame_err,
    output busy,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  overrun,
    input  frame_err,
    input  busy,
    output data_ack
  );
endinterface

// File: rtl/shift_reg_mcu_spi_rx.sv
// SPI mode-0 peripheral receiver: oversamples MCU sck/cs_n/sdi in the fpga_sck
// domain, shifts words in MSB first and offers each word on a valid/ack handshake.
module shift_reg_mcu_spi_rx #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   fpga_sck,
  input  logic                   reset_n,
  input  logic                   mcu_sck,
  input  logic                   mcu_cs_n,
  input  logic                   mcu_sdi,
  shift_reg_mcu_spi_rx_if.master bus
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  logic                   w_sck;
  logic                   w_cs_n;
  logic                   w_sdi;
  logic                   w_sck_rise;
  logic                   w_cs_fall;
  logic                   w_cs_rise;

  state_t                 r_state;
  logic [WIDTH-1:0]       r_shreg;
  logic [CW-1:0]          r_count;
  logic                   r_done;
  logic                   r_frame_err;
  logic                   r_busy;

  logic [WIDTH-1:0]       r_data_out;
  logic                   r_data_valid;
  logic                   r_overrun;

  // sdi shares the stage count of sck so the sampled bit lines up with the edge.
  always_ff @(posedge fpga_sck or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync <= '0;
      r_cs_sync  <= '1;
      r_sdi_sync <= '0;
      r_sck_prev <= 1'b0;
      r_cs_prev  <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], mcu_sck};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], mcu_cs_n};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], mcu_sdi};
      r_sck_prev <= w_sck;
      r_cs_prev  <= w_cs_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_cs_fall  = ~w_cs_n & r_cs_prev;
  assign w_cs_rise  = w_cs_n & ~r_cs_prev;

  always_ff @(posedge fpga_sck or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_count     <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= ~w_cs_n;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) begin
            r_state <= SHIFT;
            r_count <= '0;
          end
        end
        SHIFT: begin
          // CS release wins over a coincident sck edge; a partial word is dropped.
          if (w_cs_rise) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_frame_err <= (r_count != '0);
          end else if (w_sck_rise) begin
            r_shreg <= {r_shreg[WIDTH-2:0], w_sdi};
            if (r_count == LAST_BIT) begin
              r_count <= '0;
              r_done  <= 1'b1;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // r_shreg is stable for the cycle after completion given the minimum sck phase.
  always_ff @(posedge fpga_sck or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_data_valid || bus.data_ack) begin
          r_data_out   <= r_shreg;
          r_data_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (bus.data_ack && r_data_valid) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frame_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_shift_reg_mcu_spi_rx.sv
// Directed bench for shift_reg_mcu_spi_rx: event-queue model of the SPI frame
// rules compared every cycle, plus literal expectations per scenario.
module tb_shift_reg_mcu_spi_rx;
  localparam int unsigned WIDTH       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  // raw pin change (at a negedge) -> edge at which the receiver acts on it
  localparam int          LAT         = SYNC_STAGES + 1;

  logic fpga_sck = 1'b0;
  logic reset_n  = 1'b0;
  logic mcu_sck  = 1'b0;
  logic mcu_cs_n = 1'b1;
  logic mcu_sdi  = 1'b0;
  logic data_ack = 1'b0;

  shift_reg_mcu_spi_rx_if #(.WIDTH(WIDTH)) bus ();
  assign bus.data_ack = data_ack;

  shift_reg_mcu_spi_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .fpga_sck (fpga_sck),
    .reset_n  (reset_n),
    .mcu_sck  (mcu_sck),
    .mcu_cs_n (mcu_cs_n),
    .mcu_sdi  (mcu_sdi),
    .bus      (bus)
  );

  always #5 fpga_sck = ~fpga_sck;

  typedef enum int {EV_CS_FALL, EV_CS_RISE, EV_BIT} ev_kind_t;
  typedef struct {
    int       due;
    ev_kind_t kind;
    logic     val;
  } ev_t;

  ev_t evq[$];
  int  cyc    = 0;
  int  rd_idx = 0;

  logic             m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, m_busy = 1'b0;
  logic             m_pend = 1'b0, m_in_frame = 1'b0;
  logic [WIDTH-1:0] m_data = '0, m_pend_word = '0, m_bits = '0;
  int               m_nbits = 0;

  // Model: pin events take effect LAT edges after they are driven; a word
  // becomes visible one edge after its last bit, subject to the handshake rules.
  always @(posedge fpga_sck) begin : model
    int c, nb, ri;
    logic v, ov, fe, bz, pd, inf;
    logic [WIDTH-1:0] d, pw, acc;
    ev_t e;
    c = cyc + 1;  v = m_valid; d = m_data; pd = m_pend; pw = m_pend_word;
    bz = m_busy;  inf = m_in_frame; acc = m_bits; nb = m_nbits; ri = rd_idx;
    ov = 1'b0;    fe = 1'b0;
    if (!reset_n) begin
      v = 1'b0; d = '0; pd = 1'b0; bz = 1'b0; inf = 1'b0; acc = '0; nb = 0;
      ri = evq.size();
    end else begin
      if (pd) begin
        if (!v || data_ack) begin d = pw; v = 1'b1; end
        else ov = 1'b1;
        pd = 1'b0;
      end else if (data_ack && v) begin
        v = 1'b0;
      end
      while (ri < evq.size() && evq[ri].due <= c) begin
        e = evq[ri];
        ri++;
        case (e.kind)
          EV_CS_FALL: begin bz = 1'b1; inf = 1'b1; nb = 0; end
          EV_CS_RISE: begin
            bz = 1'b0;
            if (inf && nb != 0) fe = 1'b1;
            inf = 1'b0; nb = 0;
          end
          default: if (inf) begin
            acc = {acc[WIDTH-2:0], e.val};
            nb++;
            if (nb == int'(WIDTH)) begin pd = 1'b1; pw = acc; nb = 0; end
          end
        endcase
      end
    end
    cyc <= c; m_valid <= v; m_data <= d; m_pend <= pd; m_pend_word <= pw;
    m_busy <= bz; m_in_frame <= inf; m_bits <= acc; m_nbits <= nb; rd_idx <= ri;
    m_ovr <= ov; m_ferr <= fe;
  end

  int               checks = 0, errors = 0;
  int               ovr_seen = 0, ferr_seen = 0;
  logic [WIDTH-1:0] words_seen[$];
  logic             prev_valid = 1'b0;
  bit               auto_ack = 1'b0;
  int               last_rise = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: wait for the inactive edge, compare against the model, run the consumer.
  task automatic tick();
    @(negedge fpga_sck);
    if (reset_n) begin
      check("data_valid", 32'(bus.data_valid), 32'(m_valid));
      check("data_out",   32'(bus.data_out),   32'(m_data));
      check("overrun",    32'(bus.overrun),    32'(m_ovr));
      check("frame_err",  32'(bus.frame_err),  32'(m_ferr));
      check("busy",       32'(bus.busy),       32'(m_busy));
      if (bus.overrun)   ovr_seen++;
      if (bus.frame_err) ferr_seen++;
      if (bus.data_valid && !prev_valid) words_seen.push_back(bus.data_out);
      prev_valid = bus.data_valid;
      if (auto_ack) data_ack = bus.data_valid;
    end else begin
      prev_valid = 1'b0;
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic v);
    ev_t e;
    e.due = cyc + LAT; e.kind = k; e.val = v;
    evq.push_back(e);
  endtask

  task automatic cs_low();
    mcu_cs_n = 1'b0; push_ev(EV_CS_FALL, 1'b0);
    repeat (4) tick();
  endtask

  task automatic cs_high();
    mcu_cs_n = 1'b1; push_ev(EV_CS_RISE, 1'b0);
    repeat (6) tick();
  endtask

  // One bit at fpga_sck/8; optionally acks exactly in the cycle a completed word loads.
  task automatic send_bit(input logic b, input bit ack_at_load);
    mcu_sdi = b;
    repeat (4) tick();
    mcu_sck = 1'b1; push_ev(EV_BIT, b); last_rise = cyc;
    repeat (3) tick();
    if (ack_at_load) data_ack = 1'b1;
    tick();
    if (ack_at_load) data_ack = 1'b0;
    mcu_sck = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit ack_last);
    for (int i = int'(WIDTH) - 1; i >= 0; i--) send_bit(w[i], ack_last && (i == 0));
  endtask

  initial begin
    int n, o0, f0;
    logic [WIDTH-1:0] part;
    repeat (3) tick();
    check("rst data_out",   32'(bus.data_out),   0);
    check("rst data_valid", 32'(bus.data_valid), 0);
    check("rst busy",       32'(bus.busy),       0);
    reset_n = 1'b1;
    tick();

    // single word, latency, ack
    cs_low();
    check("t1 busy", 32'(bus.busy), 1);
    send_word(16'hA55A, 1'b0);
    n = 0;
    while (!bus.data_valid && n < 10) begin tick(); n++; end
    check("t1 latency_within_5", 32'(cyc - last_rise <= int'(SYNC_STAGES) + 3), 1);
    check("t1 data_valid", 32'(bus.data_valid), 1);
    check("t1 data_out",   32'(bus.data_out), 32'h0000A55A);
    cs_high();
    check("t1 no errors", 32'(ovr_seen + ferr_seen), 0);
    data_ack = 1'b1; tick(); data_ack = 1'b0;
    check("t1 valid after ack", 32'(bus.data_valid), 0);

    // back-to-back words in one frame, consumer acks immediately
    words_seen.delete();
    auto_ack = 1'b1;
    cs_low();
    send_word(16'h1234, 1'b0);
    send_word(16'hBEEF, 1'b0);
    cs_high();
    auto_ack = 1'b0; data_ack = 1'b0;
    tick();
    check("t2 word count", 32'(words_seen.size()), 2);
    if (words_seen.size() >= 2) begin
      check("t2 word0", 32'(words_seen[0]), 32'h00001234);
      check("t2 word1", 32'(words_seen[1]), 32'h0000BEEF);
    end
    check("t2 no errors", 32'(ovr_seen + ferr_seen), 0);

    // overrun: second word dropped while first is unconsumed
    o0 = ovr_seen;
    cs_low();
    send_word(16'h0001, 1'b0);
    send_word(16'h0002, 1'b0);
    cs_high();
    check("t3 overrun pulses", 32'(ovr_seen - o0), 1);
    check("t3 data_out",       32'(bus.data_out), 32'h00000001);
    check("t3 data_valid",     32'(bus.data_valid), 1);

    // ack in the same cycle the next word loads
    cs_low();
    send_word(16'h0002, 1'b1);
    cs_high();
    check("t4 no new overrun", 32'(ovr_seen - o0), 1);
    check("t4 data_valid",     32'(bus.data_valid), 1);
    check("t4 data_out",       32'(bus.data_out), 32'h00000002);
    data_ack = 1'b1; tick(); data_ack = 1'b0;
    check("t4 valid after ack", 32'(bus.data_valid), 0);

    // partial frame then a full frame
    f0 = ferr_seen;
    part = 16'h0055;
    cs_low();
    for (int i = 6; i >= 0; i--) send_bit(part[i], 1'b0);
    cs_high();
    check("t5 frame_err pulses", 32'(ferr_seen - f0), 1);
    check("t5 valid stays 0",    32'(bus.data_valid), 0);
    cs_low();
    send_word(16'hC3C3, 1'b0);
    cs_high();
    check("t5 data_out",   32'(bus.data_out), 32'h0000C3C3);
    check("t5 data_valid", 32'(bus.data_valid), 1);
    check("t5 no extra frame_err", 32'(ferr_seen - f0), 1);

    // reset mid-word
    part = 16'h5AA5;
    cs_low();
    for (int i = 15; i >= 7; i--) send_bit(part[i], 1'b0);
    reset_n = 1'b0;
    #1;
    check("t6 rst data_out",   32'(bus.data_out),   0);
    check("t6 rst data_valid", 32'(bus.data_valid), 0);
    check("t6 rst overrun",    32'(bus.overrun),    0);
    check("t6 rst frame_err",  32'(bus.frame_err),  0);
    check("t6 rst busy",       32'(bus.busy),       0);
    mcu_cs_n = 1'b1; mcu_sck = 1'b0; mcu_sdi = 1'b0;
    repeat (4) tick();
    reset_n = 1'b1;
    tick();
    cs_low();
    send_word(16'h00FF, 1'b0);
    cs_high();
    check("t6 data_out",   32'(bus.data_out), 32'h000000FF);
    check("t6 data_valid", 32'(bus.data_valid), 1);
    check("t6 no frame_err", 32'(ferr_seen - f0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
